// File: rtl/spi_regbank_pkg.sv
// Shared encodings for the SPI register bank: FSM states, command fields,
// the filler byte and status-byte layout.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TXSTATUS = 2'd1,
        ST_TXREG    = 2'd2,
        ST_RXREG    = 2'd3
    } state_e;

    localparam logic [1:0] OP_STATUS = 2'b00;
    localparam logic [1:0] OP_RD     = 2'b10;
    localparam logic [1:0] OP_WR     = 2'b11;

    localparam int OP_LSB    = 6;
    localparam int BURST_BIT = 5;
    localparam int RSVD_BIT  = 4;
    localparam int IDX_W     = 4;

    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam logic [7:0] STATUS_CMD = {OP_STATUS, 6'b000000};

    localparam int ST_ERR_ADDR  = 0;
    localparam int ST_ERR_RO    = 1;
    localparam int ST_ERR_ABORT = 2;

    function automatic logic [7:0] statusByte(input logic [3:0] id,
                                              input logic errAbort,
                                              input logic errRo,
                                              input logic errAddr);
        logic [7:0] s;
        s               = {id, 4'h0};
        s[ST_ERR_ABORT] = errAbort;
        s[ST_ERR_RO]    = errRo;
        s[ST_ERR_ADDR]  = errAddr;
        return s;
    endfunction

endpackage

// File: rtl/spi_regbank_shadow.sv
// Word-wide shift/snapshot register with byte counter; reads shift bytes out
// of the top, writes shift received bytes in at the bottom.
module spi_regbank_shadow #(
    parameter  int REG_BYTES = 4,
    localparam int W         = REG_BYTES * 8,
    localparam int CNT_W     = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1
) (
    input  logic             sysClk,
    input  logic             usrReset_n,
    input  logic             clear_i,
    input  logic             snap_i,
    input  logic [W-1:0]     snapData_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [W-1:0]     shifted_o,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [W-1:0]     shadowQ, shadowD;
    logic [CNT_W-1:0] countQ, countD;

    assign shifted_o = (shadowQ << 8) | W'(byte_i);
    assign last_o    = (countQ == CNT_W'(REG_BYTES - 1));
    assign count_o   = countQ;

    // A snapshot beats a shift so a burst read can reload on its last byte.
    always_comb begin
        shadowD = shadowQ;
        countD  = countQ;
        if (clear_i) begin
            shadowD = '0;
            countD  = '0;
        end else if (snap_i) begin
            shadowD = snapData_i;
            countD  = '0;
        end else if (shift_i) begin
            shadowD = shifted_o;
            countD  = last_o ? '0 : countQ + CNT_W'(1);
        end
    end

    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            shadowQ <= '0;
            countQ  <= '0;
        end else begin
            shadowQ <= shadowD;
            countQ  <= countD;
        end
    end

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI message layer: decodes status/read/write commands against a register
// bank with burst access, shadowed commits, read-only mask and sticky errors.
module spi_slave_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                 NUM_REGS  = 8,
    parameter int                 REG_BYTES = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 8'h80,
    parameter logic [3:0]         STATUS_ID = 4'hA
) (
    input  logic                            sysClk,
    input  logic                            usrReset_n,
    input  logic                            rxValid,
    input  logic [7:0]                      rx,
    input  logic                            frameEnd,
    output logic [7:0]                      tx,
    output logic [NUM_REGS*REG_BYTES*8-1:0] regsFlat,
    output logic [NUM_REGS-1:0]             wrStrobe
);

    localparam int W      = REG_BYTES * 8;
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

    state_e              stateQ, stateD;
    logic [ADDR_W-1:0]   idxQ, idxD;
    logic                burstQ, burstD;
    logic [7:0]          txQ, txD;
    logic [NUM_REGS-1:0] wrStrobeQ, wrStrobeD;
    logic                errAddrQ, errAddrD, errRoQ, errRoD, errAbortQ, errAbortD;
    logic [W-1:0]        regsQ [NUM_REGS];

    logic                commitEn;
    logic                shClear, shSnap, shShift, shLast;
    logic [ADDR_W-1:0]   shSnapIdx;
    logic [W-1:0]        shShifted;
    logic [CNT_W-1:0]    shCount;

    logic [1:0]          cmdOp;
    logic [ADDR_W-1:0]   cmdIdx, idxInc;
    logic                cmdOk;

    assign cmdOp  = rx[OP_LSB +: 2];
    assign cmdIdx = rx[ADDR_W-1:0];
    assign idxInc = idxQ + ADDR_W'(1);
    assign cmdOk  = ((cmdOp == OP_RD) || (cmdOp == OP_WR)) && !rx[RSVD_BIT] &&
                    ({1'b0, rx[IDX_W-1:0]} < 5'(NUM_REGS));

    spi_regbank_shadow #(.REG_BYTES(REG_BYTES)) uShadow (
        .sysClk     (sysClk),
        .usrReset_n (usrReset_n),
        .clear_i    (shClear),
        .snap_i     (shSnap),
        .snapData_i (regsQ[shSnapIdx]),
        .shift_i    (shShift),
        .byte_i     (rx),
        .shifted_o  (shShifted),
        .count_o    (shCount),
        .last_o     (shLast)
    );

    // The byte is handled first; a coincident frameEnd then overrides state.
    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        burstD    = burstQ;
        txD       = txQ;
        wrStrobeD = '0;
        errAddrD  = errAddrQ;
        errRoD    = errRoQ;
        errAbortD = errAbortQ;
        commitEn  = 1'b0;
        shClear   = 1'b0;
        shSnap    = 1'b0;
        shShift   = 1'b0;
        shSnapIdx = idxQ;

        if (rxValid) begin
            unique case (stateQ)
                ST_IDLE: begin
                    if (rx == STATUS_CMD) begin
                        txD       = statusByte(STATUS_ID, errAbortQ, errRoQ, errAddrQ);
                        errAddrD  = 1'b0;
                        errRoD    = 1'b0;
                        errAbortD = 1'b0;
                        stateD    = ST_TXSTATUS;
                    end else if (cmdOk) begin
                        idxD   = cmdIdx;
                        burstD = rx[BURST_BIT];
                        if (cmdOp == OP_RD) begin
                            stateD    = ST_TXREG;
                            shSnap    = 1'b1;
                            shSnapIdx = cmdIdx;
                            txD       = regsQ[cmdIdx][W-1 -: 8];
                        end else begin
                            stateD  = ST_RXREG;
                            shClear = 1'b1;
                            txD     = FILL_BYTE;
                        end
                    end else begin
                        errAddrD = 1'b1;
                        txD      = FILL_BYTE;
                    end
                end
                ST_TXSTATUS: begin
                    stateD = ST_IDLE;
                    txD    = FILL_BYTE;
                end
                ST_TXREG: begin
                    shShift = 1'b1;
                    if (!shLast) begin
                        txD = shShifted[W-1 -: 8];
                    end else if (burstQ) begin
                        idxD      = idxInc;
                        shSnap    = 1'b1;
                        shSnapIdx = idxInc;
                        txD       = regsQ[idxInc][W-1 -: 8];
                    end else begin
                        stateD = ST_IDLE;
                        txD    = FILL_BYTE;
                    end
                end
                ST_RXREG: begin
                    shShift = 1'b1;
                    txD     = FILL_BYTE;
                    if (shLast) begin
                        if (RO_MASK[idxQ]) begin
                            errRoD = 1'b1;
                        end else begin
                            commitEn        = 1'b1;
                            wrStrobeD[idxQ] = 1'b1;
                        end
                        if (burstQ) idxD = idxInc;
                        else        stateD = ST_IDLE;
                    end
                end
                default: stateD = ST_IDLE;
            endcase
        end

        if (frameEnd) begin
            if (((stateQ == ST_TXREG) || (stateQ == ST_RXREG)) &&
                (rxValid ? !shLast : (shCount != '0)))
                errAbortD = 1'b1;
            stateD  = ST_IDLE;
            txD     = FILL_BYTE;
            shClear = 1'b1;
        end
    end

    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            stateQ    <= ST_IDLE;
            idxQ      <= '0;
            burstQ    <= 1'b0;
            txQ       <= 8'h00;
            wrStrobeQ <= '0;
            errAddrQ  <= 1'b0;
            errRoQ    <= 1'b0;
            errAbortQ <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regsQ[i] <= '0;
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            burstQ    <= burstD;
            txQ       <= txD;
            wrStrobeQ <= wrStrobeD;
            errAddrQ  <= errAddrD;
            errRoQ    <= errRoD;
            errAbortQ <= errAbortD;
            if (commitEn) regsQ[idxQ] <= shShifted;
        end
    end

    assign tx       = txQ;
    assign wrStrobe = wrStrobeQ;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
        assign regsFlat[g*W +: W] = regsQ[g];
    end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench for spi_slave_regbank with a tx scoreboard queue and a
// register-bank model checked after every byte.
module tb_spi_slave_regbank;

    localparam int NR = 8;
    localparam int RB = 4;

    logic            sysClk = 1'b0;
    logic            usrReset_n;
    logic            rxValid;
    logic [7:0]      rx;
    logic            frameEnd;
    logic [7:0]      tx;
    logic [NR*RB*8-1:0] regsFlat;
    logic [NR-1:0]   wrStrobe;

    int testsRun  = 0;
    int failCount = 0;

    logic [RB*8-1:0] model [NR];
    logic [7:0]      expTxQ [$];

    spi_slave_regbank #(
        .NUM_REGS  (NR),
        .REG_BYTES (RB),
        .RO_MASK   (8'h80),
        .STATUS_ID (4'hA)
    ) dut (
        .sysClk     (sysClk),
        .usrReset_n (usrReset_n),
        .rxValid    (rxValid),
        .rx         (rx),
        .frameEnd   (frameEnd),
        .tx         (tx),
        .regsFlat   (regsFlat),
        .wrStrobe   (wrStrobe)
    );

    always #5 sysClk = ~sysClk;

    function automatic logic [NR*RB*8-1:0] flatModel();
        logic [NR*RB*8-1:0] f;
        for (int i = 0; i < NR; i++) f[i*RB*8 +: RB*8] = model[i];
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] expStrobe);
        checkOutput({tag, ".tx"}, 256'(tx), 256'(expTxQ.pop_front()));
        checkOutput({tag, ".wrStrobe"}, 256'(wrStrobe), 256'(expStrobe));
        checkOutput({tag, ".regsFlat"}, 256'(regsFlat), 256'(flatModel()));
    endtask

    // One byte (optionally with a coincident frameEnd), checked #1 after the edge.
    task automatic applyStimulus(input string tag, input logic [7:0] b, input logic fe,
                                 input logic [7:0] expTx, input logic [7:0] expStrobe);
        @(negedge sysClk);
        rxValid  = 1'b1;
        rx       = b;
        frameEnd = fe;
        expTxQ.push_back(expTx);
        @(posedge sysClk);
        #1;
        rxValid  = 1'b0;
        frameEnd = 1'b0;
        rx       = 8'h00;
        checkAll(tag, expStrobe);
    endtask

    task automatic applyFrameEnd(input string tag);
        @(negedge sysClk);
        frameEnd = 1'b1;
        expTxQ.push_back(8'hFF);
        @(posedge sysClk);
        #1;
        frameEnd = 1'b0;
        checkAll(tag, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        usrReset_n = 1'b0;
        rxValid    = 1'b0;
        rx         = 8'h00;
        frameEnd   = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("reset.tx", 256'(tx), 256'(8'h00));
        checkOutput("reset.wrStrobe", 256'(wrStrobe), 256'(0));
        checkOutput("reset.regsFlat", 256'(regsFlat), 256'(0));
        @(negedge sysClk);
        usrReset_n = 1'b1;

        applyStimulus("stat0", 8'h00, 1'b0, 8'hA0, 8'h00);
        applyStimulus("stat0d", 8'h55, 1'b0, 8'hFF, 8'h00);

        applyStimulus("wr3.cmd", 8'hC3, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr3.b1", 8'h12, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr3.b2", 8'h34, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr3.b3", 8'h56, 1'b0, 8'hFF, 8'h00);
        model[3] = 32'h12345678;
        applyStimulus("wr3.b4", 8'h78, 1'b0, 8'hFF, 8'h08);
        @(posedge sysClk);
        #1;
        checkOutput("wr3.strobeDrop", 256'(wrStrobe), 256'(0));

        applyStimulus("bw6.cmd", 8'hE6, 1'b0, 8'hFF, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] strobe;
            strobe = 8'h00;
            if (i == 4) begin
                model[6] = 32'h01020304;
                strobe   = 8'h40;
            end
            applyStimulus("bw6.data", 8'(i), 1'b0, 8'hFF, strobe);
        end
        applyFrameEnd("bw6.end");
        applyStimulus("stat1", 8'h00, 1'b0, 8'hA2, 8'h00);
        applyStimulus("stat1d", 8'h00, 1'b0, 8'hFF, 8'h00);
        applyStimulus("stat2", 8'h00, 1'b0, 8'hA0, 8'h00);
        applyStimulus("stat2d", 8'h00, 1'b0, 8'hFF, 8'h00);

        applyStimulus("wr0.cmd", 8'hC0, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr0.b1", 8'hAA, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr0.b2", 8'hBB, 1'b0, 8'hFF, 8'h00);
        applyStimulus("wr0.b3", 8'hCC, 1'b0, 8'hFF, 8'h00);
        model[0] = 32'hAABBCCDD;
        applyStimulus("wr0.b4", 8'hDD, 1'b0, 8'hFF, 8'h01);

        // Burst read from reg7 wraps to reg0, then into reg1's MSB.
        applyStimulus("br7.cmd", 8'hA7, 1'b0, model[7][31:24], 8'h00);
        applyStimulus("br7.d1", 8'h00, 1'b0, model[7][23:16], 8'h00);
        applyStimulus("br7.d2", 8'h00, 1'b0, model[7][15:8], 8'h00);
        applyStimulus("br7.d3", 8'h00, 1'b0, model[7][7:0], 8'h00);
        applyStimulus("br7.d4", 8'h00, 1'b0, 8'hAA, 8'h00);
        applyStimulus("br7.d5", 8'h00, 1'b0, 8'hBB, 8'h00);
        applyStimulus("br7.d6", 8'h00, 1'b0, 8'hCC, 8'h00);
        applyStimulus("br7.d7", 8'h00, 1'b0, 8'hDD, 8'h00);
        applyStimulus("br7.d8", 8'h00, 1'b0, model[1][31:24], 8'h00);
        applyFrameEnd("br7.end");
        applyStimulus("stat3", 8'h00, 1'b0, 8'hA0, 8'h00);
        applyStimulus("stat3d", 8'h00, 1'b0, 8'hFF, 8'h00);

        applyStimulus("ab2.cmd", 8'hC2, 1'b0, 8'hFF, 8'h00);
        applyStimulus("ab2.b1", 8'h11, 1'b0, 8'hFF, 8'h00);
        applyStimulus("ab2.b2", 8'h22, 1'b0, 8'hFF, 8'h00);
        applyFrameEnd("ab2.end");
        applyStimulus("stat4", 8'h00, 1'b0, 8'hA4, 8'h00);
        applyStimulus("stat4d", 8'h00, 1'b0, 8'hFF, 8'h00);

        applyStimulus("bad.idx", 8'h8A, 1'b0, 8'hFF, 8'h00);
        applyStimulus("bad.stat", 8'h01, 1'b0, 8'hFF, 8'h00);
        applyStimulus("bad.rsvd", 8'hD0, 1'b0, 8'hFF, 8'h00);
        applyStimulus("stat5", 8'h00, 1'b0, 8'hA1, 8'h00);
        applyStimulus("stat5d", 8'h00, 1'b0, 8'hFF, 8'h00);

        // Final byte and frameEnd on the same edge: commit, no abort.
        applyStimulus("fe1.cmd", 8'hC1, 1'b0, 8'hFF, 8'h00);
        applyStimulus("fe1.b1", 8'h11, 1'b0, 8'hFF, 8'h00);
        applyStimulus("fe1.b2", 8'h22, 1'b0, 8'hFF, 8'h00);
        applyStimulus("fe1.b3", 8'h33, 1'b0, 8'hFF, 8'h00);
        model[1] = 32'h11223344;
        applyStimulus("fe1.b4", 8'h44, 1'b1, 8'hFF, 8'h02);
        applyStimulus("stat6", 8'h00, 1'b0, 8'hA0, 8'h00);
        applyStimulus("stat6d", 8'h00, 1'b0, 8'hFF, 8'h00);

        applyStimulus("rd1.cmd", 8'h81, 1'b0, 8'h11, 8'h00);
        applyStimulus("rd1.d1", 8'h00, 1'b0, 8'h22, 8'h00);
        applyStimulus("rd1.d2", 8'h00, 1'b0, 8'h33, 8'h00);
        applyStimulus("rd1.d3", 8'h00, 1'b0, 8'h44, 8'h00);
        applyStimulus("rd1.d4", 8'h00, 1'b0, 8'hFF, 8'h00);

        applyStimulus("rst.cmd", 8'hE4, 1'b0, 8'hFF, 8'h00);
        applyStimulus("rst.b1", 8'h11, 1'b0, 8'hFF, 8'h00);
        applyStimulus("rst.b2", 8'h22, 1'b0, 8'hFF, 8'h00);
        @(negedge sysClk);
        #2;
        usrReset_n = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        checkOutput("rst.tx", 256'(tx), 256'(8'h00));
        checkOutput("rst.wrStrobe", 256'(wrStrobe), 256'(0));
        checkOutput("rst.regsFlat", 256'(regsFlat), 256'(flatModel()));
        @(posedge sysClk);
        #1;
        checkOutput("rst.hold", 256'(regsFlat), 256'(0));
        @(negedge sysClk);
        usrReset_n = 1'b1;
        applyStimulus("rst.stat", 8'h00, 1'b0, 8'hA0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
